// File: rtl/regfile_write_port.sv
// 32 x WIDTH register file write end: one-hot write decode, two bypassable
// read ports, a debug read port and a sequential bulk-clear engine.
//
// state | meaning
// IDLE  | normal operation, writes accepted, clr starts a clear sweep
// CLEAR | sweeping r1..r31 to zero, one entry per cycle, writes dropped
module regfile_write_port #(
  parameter int WIDTH  = 32,
  parameter bit BYPASS = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [4:0]       waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [4:0]       raddr_a,
  input  logic [4:0]       raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b,
  input  logic [4:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data,
  input  logic             clr,
  output logic             busy,
  output logic             clr_done
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state, state_nxt;
  logic [4:0]       cnt, cnt_nxt;
  logic             clr_done_nxt;
  logic [31:0]      en;
  logic [WIDTH-1:0] mem [32];
  logic             hit_a, hit_b;

  assign busy = (state == CLEAR);

  always_comb begin
    en = '0;
    for (int i = 1; i < 32; i++) begin
      en[i] = we & (waddr == 5'(i)) & ~busy;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    clr_done_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (clr) begin
          state_nxt = CLEAR;
          cnt_nxt   = 5'd1;
        end
      end
      CLEAR: begin
        // exit is decided before incrementing so the counter never wraps
        if (cnt == 5'd31) begin
          state_nxt    = IDLE;
          cnt_nxt      = 5'd0;
          clr_done_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 5'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 5'd0;
      clr_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      clr_done <= clr_done_nxt;
    end
  end

  // entry 0 is only ever written by reset, so it reads back as zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (en[i]) begin
          mem[i] <= wdata;
        end else if (busy && (cnt == 5'(i))) begin
          mem[i] <= '0;
        end
      end
    end
  end

  assign hit_a = BYPASS && we && !busy && (waddr != 5'd0) && (waddr == raddr_a);
  assign hit_b = BYPASS && we && !busy && (waddr != 5'd0) && (waddr == raddr_b);

  assign rdata_a  = (raddr_a == 5'd0) ? '0 : (hit_a ? wdata : mem[raddr_a]);
  assign rdata_b  = (raddr_b == 5'd0) ? '0 : (hit_b ? wdata : mem[raddr_b]);
  assign dbg_data = mem[dbg_addr];

endmodule

// File: tb/tb_regfile_write_port.sv
// Scoreboard bench for regfile_write_port: stimulus queues per-cycle
// expectations, a negedge monitor pops and compares them.
module tb_regfile_write_port;

  localparam int WIDTH = 32;

  logic             clk = 1'b1;
  logic             rst;
  logic             we;
  logic [4:0]       waddr;
  logic [WIDTH-1:0] wdata;
  logic [4:0]       raddr_a, raddr_b, dbg_addr;
  logic             clr;
  logic [WIDTH-1:0] rdata_a, rdata_b, dbg_data;
  logic             busy, clr_done;
  logic [WIDTH-1:0] rdata_a0, rdata_b0, dbg_data0;
  logic             busy0, clr_done0;

  regfile_write_port #(.WIDTH(WIDTH), .BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .clr(clr), .busy(busy),
    .clr_done(clr_done)
  );

  regfile_write_port #(.WIDTH(WIDTH), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a0), .rdata_b(rdata_b0),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data0), .clr(clr), .busy(busy0),
    .clr_done(clr_done0)
  );

  always #5 clk = ~clk;

  typedef enum int {K_A, K_B, K_DBG, K_BUSY, K_DONE, K_B_NB, K_BUSY_NB} kind_t;
  typedef struct {
    int               cyc;
    kind_t            kind;
    logic [WIDTH-1:0] val;
    string            name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [WIDTH-1:0] actual(input kind_t k);
    case (k)
      K_A:       return rdata_a;
      K_B:       return rdata_b;
      K_DBG:     return dbg_data;
      K_BUSY:    return WIDTH'(busy);
      K_DONE:    return WIDTH'(clr_done);
      K_B_NB:    return rdata_b0;
      K_BUSY_NB: return WIDTH'(busy0);
      default:   return 'x;
    endcase
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      automatic exp_t e = q.pop_front();
      automatic logic [WIDTH-1:0] act = actual(e.kind);
      n_checks++;
      if (act === e.val) n_pass++;
      else $display("FAIL %s (cycle %0d): got 0x%08h, expected 0x%08h",
                    e.name, e.cyc, act, e.val);
    end
  end

  task automatic expect_val(input kind_t k, input logic [WIDTH-1:0] v, input string name);
    exp_t e;
    e.cyc = cyc; e.kind = k; e.val = v; e.name = name;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_index();
    for (int i = 1; i < 32; i++) begin
      we = 1'b1; waddr = 5'(i); wdata = WIDTH'(i);
      tick();
    end
    we = 1'b0;
    dbg_addr = 5'd17;
    expect_val(K_DBG, 32'd17, "fill_r17");
  endtask

  // Registers must hold r[i]=i on entry. inject_k drives a write and a
  // second clr in that CLEAR cycle; abort_k asserts rst in that cycle.
  task automatic do_clear(input int inject_k, input int abort_k);
    clr = 1'b1; we = 1'b0;
    expect_val(K_BUSY, 0, "clr_req_busy");
    tick();
    clr = 1'b0;
    for (int k = 1; k < 32; k++) begin
      we = 1'b0; clr = 1'b0;
      dbg_addr = 5'(k); raddr_a = 5'(k - 1); raddr_b = 5'd31;
      if (k == abort_k) begin
        rst = 1'b1;
        expect_val(K_BUSY, 0, "abort_busy");
        expect_val(K_DONE, 0, "abort_done");
        expect_val(K_DBG, 0, "abort_dbg_zero");
        expect_val(K_B, 0, "abort_r31_zero");
        tick();
        rst = 1'b0;
        expect_val(K_BUSY, 0, "post_abort_busy");
        expect_val(K_DONE, 0, "post_abort_no_done");
        return;
      end
      if (k == inject_k) begin
        we = 1'b1; waddr = 5'd3; wdata = 32'hAB; clr = 1'b1;
        raddr_b = 5'd3;
        expect_val(K_B, 0, "clear_write_no_bypass");
      end else begin
        expect_val(K_B, 32'd31, "clear_r31_held");
      end
      expect_val(K_BUSY, 1, "clear_busy");
      expect_val(K_DONE, 0, "clear_no_done");
      expect_val(K_DBG, WIDTH'(k), "clear_entry_before_edge");
      expect_val(K_A, 0, "clear_prev_entry_zero");
      tick();
    end
    we = 1'b0; clr = 1'b0;
    expect_val(K_BUSY, 0, "clear_end_busy");
    expect_val(K_DONE, 1, "clear_done_pulse");
    expect_val(K_DBG, 0, "clear_r31_zero");
    tick();
    expect_val(K_DONE, 0, "clear_done_single");
    expect_val(K_BUSY, 0, "clear_idle_busy");
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i); raddr_a = 5'(i);
      expect_val(K_DBG, 0, "post_clear_dbg_zero");
      expect_val(K_A, 0, "post_clear_a_zero");
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; clr = 1'b0;
    raddr_a = 5'd5; raddr_b = 5'd0; dbg_addr = 5'd5;
    expect_val(K_BUSY, 0, "reset_busy");
    expect_val(K_DONE, 0, "reset_done");
    expect_val(K_A, 0, "reset_rdata_a");
    expect_val(K_DBG, 0, "reset_dbg");
    tick();
    rst = 1'b0;
    tick();

    // r5 write, visible the cycle after the edge
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; raddr_a = 5'd6; dbg_addr = 5'd5;
    expect_val(K_A, 0, "w5_other_read");
    expect_val(K_DBG, 0, "w5_dbg_before_edge");
    tick();
    we = 1'b0; raddr_a = 5'd5; raddr_b = 5'd9;
    expect_val(K_A, 32'hDEADBEEF, "w5_rdata_a");
    expect_val(K_DBG, 32'hDEADBEEF, "w5_dbg");
    expect_val(K_B, 0, "w5_rdata_b_other");
    tick();
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      expect_val(K_DBG, (i == 5) ? 32'hDEADBEEF : 32'h0, "w5_only_entry");
      tick();
    end

    // writes to r0 are discarded, including on the bypass path
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
    raddr_a = 5'd0; raddr_b = 5'd0; dbg_addr = 5'd0;
    expect_val(K_A, 0, "r0_bypass_a");
    expect_val(K_B, 0, "r0_bypass_b");
    tick();
    we = 1'b0;
    expect_val(K_A, 0, "r0_after_a");
    expect_val(K_DBG, 0, "r0_after_dbg");
    tick();

    // bypass vs stored value
    we = 1'b1; waddr = 5'd7; wdata = 32'h11;
    tick();
    we = 1'b1; waddr = 5'd7; wdata = 32'h22; raddr_b = 5'd7; dbg_addr = 5'd7;
    expect_val(K_B, 32'h22, "bypass_b");
    expect_val(K_B_NB, 32'h11, "nobypass_b");
    expect_val(K_DBG, 32'h11, "bypass_dbg_stored");
    tick();
    we = 1'b0;
    expect_val(K_B, 32'h22, "after_edge_b");
    expect_val(K_B_NB, 32'h22, "after_edge_b_nobypass");
    expect_val(K_DBG, 32'h22, "after_edge_dbg");
    tick();

    // full clear, clear with dropped write and ignored re-request
    fill_index();
    tick();
    do_clear(0, 0);
    fill_index();
    tick();
    do_clear(5, 0);
    dbg_addr = 5'd3;
    expect_val(K_DBG, 0, "dropped_write_r3");
    expect_val(K_BUSY_NB, 0, "nobypass_idle_busy");
    tick();

    // reset in the tenth CLEAR cycle, then a normal write
    fill_index();
    tick();
    do_clear(0, 10);
    dbg_addr = 5'd20;
    expect_val(K_DBG, 0, "abort_r20_zero");
    we = 1'b1; waddr = 5'd2; wdata = 32'h5;
    tick();
    we = 1'b0; dbg_addr = 5'd2; raddr_a = 5'd2;
    expect_val(K_DBG, 32'h5, "post_abort_write_dbg");
    expect_val(K_A, 32'h5, "post_abort_write_a");
    expect_val(K_DONE, 0, "post_abort_done_low");
    tick();

    for (int t = 0; t < 10 && q.size() > 0; t++) tick();
    if (q.size() > 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_write_port.md
Name: regfile_write_port

Overview:
- Write end of the 32-entry general-purpose register file; it is the counterpart to the 32:1 read-select muxing.
- Decodes a 5-bit write address into 32 one-hot enables and holds the 32 x WIDTH storage.
- Provides two read ports with optional same-cycle write-to-read bypass, plus a debug read port for display logic.
- Includes a sequential bulk-clear engine with a busy/done handshake; it sits at the WB/ID boundary of the pipeline.

Parameters:
WIDTH, 32, data width of each register
BYPASS, 1, 1 = read ports forward same-cycle write data; 0 = reads return stored value only

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
we  input  1  write enable from WB stage
waddr  input  5  write register index
wdata  input  WIDTH  write data
raddr_a  input  5  read port A index
raddr_b  input  5  read port B index
rdata_a  output  WIDTH  read port A data (combinational)
rdata_b  output  WIDTH  read port B data (combinational)
dbg_addr  input  5  debug read index
dbg_data  output  WIDTH  debug read data (stored value, never bypassed)
clr  input  1  bulk-clear request, sampled on rising edge
busy  output  1  clear engine active; writes ignored
clr_done  output  1  one-cycle pulse when clear completes

Behaviour:
- Reset (async, rst=1): all 32 registers = 0, FSM = IDLE, clear counter = 0, busy = 0, clr_done = 0. Reset mid-clear aborts immediately; next state is IDLE.
- Register 0 is hardwired to 0. Writes to index 0 are discarded, and reads of index 0 return 0 on every port, bypass included.
- Write decode: one-hot enable en[i] = we & (waddr==i) & (i!=0) & ~busy. The selected register takes wdata at the rising edge; all others hold. Write latency is 1 cycle to storage.
- Read A/B: purely combinational from storage. With BYPASS=1, we=1, busy=0, waddr!=0 and waddr==raddr_x, rdata_x = wdata in the same cycle. With BYPASS=0, the new value is visible on the cycle after the edge.
- dbg_data: combinational storage[dbg_addr], with no bypass.
- FSM states are IDLE and CLEAR.
  - IDLE: busy=0. clr=1 at an edge leads to CLEAR with counter = 1. A write presented in that same cycle still commits, because busy is 0 in that cycle.
  - CLEAR: busy=1. Each cycle, storage[counter] <= 0 and counter increments.
    - When counter==31 is cleared, next state is IDLE and clr_done=1 for exactly the following cycle (registered).
    - Total busy duration is 31 cycles.
    - clr asserted during CLEAR is ignored (no restart).
    - we during CLEAR is dropped without error; upstream must stall on busy.
    - Reads during CLEAR return current storage, so some entries are already zero.
- clr_done and busy are registered outputs; busy deasserts in the same cycle clr_done asserts.
- Counter is 5 bits and never wraps past 31 (exit condition is checked before increment).
- Arithmetic: none on data; width is WIDTH throughout. Unused upper address combinations do not exist (5-bit address covers exactly 32 entries).

Test Plan:
1. Reset, then write r5=0xDEADBEEF, then next cycle read raddr_a=5 -> rdata_a=0xDEADBEEF; dbg_addr=5 -> dbg_data=0xDEADBEEF; all other entries remain 0.
2. we=1, waddr=0, wdata=0xFFFFFFFF, raddr_a=0 -> rdata_a=0 in the same cycle and afterwards; storage[0] remains 0.
3. BYPASS=1: r7 holds 0x11, we=1 waddr=7 wdata=0x22 raddr_b=7 -> rdata_b=0x22 in the same cycle, dbg_data(7)=0x11 until the edge. Under BYPASS=0 the same stimulus gives rdata_b=0x11.
4. Fill r1..r31 with index values, pulse clr -> busy=1 for 31 cycles, r1 zeroed first and r31 last, clr_done pulses once in the cycle busy falls; all reads then return 0.
5. During CLEAR, assert we=1 waddr=3 wdata=0xAB and pulse clr again -> r3 stays 0, busy length is unchanged (31 cycles), a single clr_done.
6. Assert rst on cycle 10 of CLEAR -> busy=0 and all registers 0 immediately (async), clr_done not pulsed; a subsequent write r2=0x5 succeeds on the next edge.
